feature_loader: RTL and testbench

FEATURE_LOADER -- requirements
Module: feature_loader

---
 rtl/feature_loader_pkg.sv | 25 ++
 rtl/feature_loader_fifo.sv | 62 ++++++
 rtl/feature_loader.sv | 198 +++++++++++++++++++
 tb/tb_feature_loader.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/feature_loader_pkg.sv
// Shared types and constants for the feature loader: frame size, feature/index
// types, FSM state encoding and the FIFO entry packing helper.
package feature_loader_pkg;

    localparam int FEATURE_COUNT = 136;
    localparam int FEAT_W        = 8;
    localparam int ENTRY_W       = FEAT_W + 1;

    typedef logic [FEAT_W-1:0] feature_t;
    typedef logic [FEAT_W-1:0] index_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_WAIT   = 3'd2,
        ST_RESULT = 3'd3,
        ST_DRAIN  = 3'd4
    } state_t;

    // A FIFO entry carries the end-of-frame flag above the feature byte.
    function automatic logic [ENTRY_W-1:0] pack_entry(input logic last, input feature_t data);
        return {last, data};
    endfunction

endpackage

// File: rtl/feature_loader_fifo.sv
// Synchronous FIFO with combinational read data at the head. A push is taken
// only when not full and a pop only when not empty, both judged before the edge.
module feature_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 9
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_r == (AW+1)'(DEPTH));
    assign empty     = (count_r == (AW+1)'(0));
    assign count     = count_r;
    assign pop_data  = mem_r[rd_ptr_r];
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;

    // Storage array; contents are don't-care while the entry is unoccupied.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= (AW+1)'(0);
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/feature_loader.sv
// Streams one frame of feature bytes into a MAC engine, waits for the result
// with a watchdog, and hands the captured result to a downstream consumer.
module feature_loader
    import feature_loader_pkg::*;
#(
    parameter int FEATURE_COUNT = feature_loader_pkg::FEATURE_COUNT,
    parameter int FIFO_DEPTH    = 16,
    parameter int TIMEOUT       = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       s_valid,
    input  logic [7:0] s_data,
    input  logic       s_last,
    output logic       s_ready,
    output logic       mac_start,
    output logic [7:0] mac_data,
    output logic [7:0] mac_index,
    input  logic [7:0] mac_out,
    input  logic       mac_done,
    output logic       r_valid,
    output logic [7:0] r_data,
    input  logic       r_ready,
    output logic       busy,
    output logic       err_len,
    output logic       err_timeout
);

    localparam index_t     LAST_IDX = index_t'(FEATURE_COUNT - 1);
    localparam logic [7:0] WD_LAST  = 8'(TIMEOUT - 1);

    state_t               state_r, state_next_s;
    index_t               cnt_r, cnt_next_s;
    logic [7:0]           wd_r, wd_next_s;
    logic [ENTRY_W-1:0]   fifo_head_s;
    logic                 fifo_full_s;
    logic                 fifo_empty_s;
    logic [$clog2(FIFO_DEPTH):0] fifo_level_unused_s;
    logic                 entry_last_s;
    feature_t             entry_data_s;
    logic                 pop_s, issue_s, err_len_s, err_to_s, capture_s, release_s;

    logic                 mac_start_r, r_valid_r, busy_r, err_len_r, err_timeout_r;
    feature_t             mac_data_r, r_data_r;
    index_t               mac_index_r;

    feature_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(ENTRY_W)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (s_valid),
        .push_data (pack_entry(s_last, s_data)),
        .pop       (pop_s),
        .pop_data  (fifo_head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .count     (fifo_level_unused_s)
    );

    assign s_ready      = !fifo_full_s;
    assign entry_last_s = fifo_head_s[ENTRY_W-1];
    assign entry_data_s = fifo_head_s[FEAT_W-1:0];

    // Next-state logic: decides pops, feature issue, errors and result hand-off.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        wd_next_s    = wd_r;
        pop_s        = 1'b0;
        issue_s      = 1'b0;
        err_len_s    = 1'b0;
        err_to_s     = 1'b0;
        capture_s    = 1'b0;
        release_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    state_next_s = ST_LOAD;
                    cnt_next_s   = 8'd0;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (!fifo_empty_s) begin
                    pop_s = 1'b1;
                    if (cnt_r == LAST_IDX) begin
                        // Final feature is always issued; a missing last flag means
                        // the frame is too long and the tail must be discarded.
                        issue_s   = 1'b1;
                        wd_next_s = 8'd0;
                        if (entry_last_s) begin
                            state_next_s = ST_WAIT;
                        end else begin
                            err_len_s    = 1'b1;
                            state_next_s = ST_DRAIN;
                        end
                    end else if (entry_last_s) begin
                        // Short frame: the early terminator is dropped.
                        err_len_s    = 1'b1;
                        state_next_s = ST_IDLE;
                    end else begin
                        issue_s    = 1'b1;
                        cnt_next_s = cnt_r + 8'd1;
                    end
                end else begin
                    state_next_s = ST_LOAD;
                end
            end
            ST_DRAIN: begin
                if (!fifo_empty_s) begin
                    pop_s = 1'b1;
                    if (entry_last_s) begin
                        state_next_s = ST_WAIT;
                        wd_next_s    = 8'd0;
                    end else begin
                        state_next_s = ST_DRAIN;
                    end
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            ST_WAIT: begin
                if (mac_done) begin
                    capture_s    = 1'b1;
                    state_next_s = ST_RESULT;
                end else if (wd_r == WD_LAST) begin
                    err_to_s     = 1'b1;
                    state_next_s = ST_IDLE;
                end else begin
                    wd_next_s = wd_r + 8'd1;
                end
            end
            ST_RESULT: begin
                if (r_ready) begin
                    release_s    = 1'b1;
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_RESULT;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State, feature counter and watchdog registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= 8'd0;
            wd_r    <= 8'd0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            wd_r    <= wd_next_s;
        end
    end

    // Registered outputs: MAC write port, result holding register, status pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mac_start_r   <= 1'b0;
            mac_data_r    <= 8'd0;
            mac_index_r   <= 8'd0;
            r_valid_r     <= 1'b0;
            r_data_r      <= 8'd0;
            busy_r        <= 1'b0;
            err_len_r     <= 1'b0;
            err_timeout_r <= 1'b0;
        end else begin
            mac_start_r   <= issue_s;
            err_len_r     <= err_len_s;
            err_timeout_r <= err_to_s;
            busy_r        <= (state_next_s != ST_IDLE);
            if (issue_s) begin
                mac_data_r  <= entry_data_s;
                mac_index_r <= cnt_r;
            end
            if (capture_s) begin
                r_valid_r <= 1'b1;
                r_data_r  <= mac_out;
            end else if (release_s) begin
                r_valid_r <= 1'b0;
            end
        end
    end

    assign mac_start   = mac_start_r;
    assign mac_data    = mac_data_r;
    assign mac_index   = mac_index_r;
    assign r_valid     = r_valid_r;
    assign r_data      = r_data_r;
    assign busy        = busy_r;
    assign err_len     = err_len_r;
    assign err_timeout = err_timeout_r;

endmodule

// File: tb/tb_feature_loader.sv
// Self-checking bench for feature_loader: random frames checked against a
// frame-level reference model, plus directed timing and error scenarios.
module tb_feature_loader;

    localparam int FC = 136;

    logic       clk = 1'b0;
    logic       rst;
    logic       s_valid, s_last, s_ready;
    logic [7:0] s_data;
    logic       mac_start, mac_done;
    logic [7:0] mac_data, mac_index, mac_out;
    logic       r_valid, r_ready, busy, err_len, err_timeout;
    logic [7:0] r_data;

    always #5 clk = ~clk;

    feature_loader #(.FEATURE_COUNT(FC), .FIFO_DEPTH(16), .TIMEOUT(255)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
        .mac_start(mac_start), .mac_data(mac_data), .mac_index(mac_index),
        .mac_out(mac_out), .mac_done(mac_done),
        .r_valid(r_valid), .r_data(r_data), .r_ready(r_ready),
        .busy(busy), .err_len(err_len), .err_timeout(err_timeout)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: records every feature write and status pulse seen by the MAC side.
    logic [15:0] obs_q[$];
    int          start_q[$];
    int          n_err_len = 0, n_to = 0, to_cyc = 0, n_rvalid = 0;
    logic [7:0]  err_len_idx = 8'd0;
    logic        err_len_with_start = 1'b0, to_busy = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (mac_start) begin
                obs_q.push_back({mac_index, mac_data});
                start_q.push_back(cyc);
            end
            if (err_len) begin
                n_err_len          <= n_err_len + 1;
                err_len_idx        <= mac_index;
                err_len_with_start <= mac_start;
            end
            if (err_timeout) begin
                n_to    <= n_to + 1;
                to_cyc  <= cyc;
                to_busy <= busy;
            end
            if (r_valid) n_rvalid <= n_rvalid + 1;
        end
    end

    int n_cmp = 0, n_bad = 0;
    logic [8:0]  tx_q[$];
    logic [15:0] exp_q[$];
    int          exp_err;
    int          first_acc_cyc;

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Frame of n bytes; last flag at last_pos; sequential or random payload.
    task automatic build_frame(input int n, input int last_pos, input bit seq);
        logic [7:0] d;
        tx_q.delete();
        for (int i = 0; i < n; i++) begin
            d = seq ? 8'(i) : 8'($urandom_range(0, 255));
            tx_q.push_back({(i == last_pos), d});
        end
    endtask

    // Reference: byte at frame position p becomes feature index p while p is
    // below the frame size; an early last aborts, a late last is drained.
    task automatic model_frame();
        logic       lst;
        logic [7:0] pos;
        exp_q.delete();
        exp_err = 0;
        for (int p = 0; p < tx_q.size(); p++) begin
            lst = tx_q[p][8];
            pos = 8'(p);
            if (p < FC - 1) begin
                if (lst) begin exp_err = 1; break; end
                exp_q.push_back({pos, tx_q[p][7:0]});
            end else if (p == FC - 1) begin
                exp_q.push_back({pos, tx_q[p][7:0]});
                if (lst) break;
                exp_err = 1;
            end else if (lst) begin
                break;
            end
        end
    endtask

    // Push tx_q[from..to-1] with valid/ready handshake; stops early once the
    // monitor has seen stop_obs feature writes.
    task automatic send_range(input int from, input int to, input int stop_obs);
        int  i, g;
        logic ok;
        i = from; g = 0;
        while (i < to && g < 40 * (to - from) + 100 && obs_q.size() < stop_obs) begin
            s_valid = 1'b1; s_data = tx_q[i][7:0]; s_last = tx_q[i][8];
            ok = s_ready;
            step();
            if (ok) begin
                if (i == from) first_acc_cyc = cyc;
                i++;
            end
            g++;
        end
        s_valid = 1'b0; s_last = 1'b0;
        if (i < to && obs_q.size() < stop_obs) chk("send_timeout", 32'(i), 32'(to));
    endtask

    task automatic check_frame(input string tag, input int base);
        int g;
        g = 0;
        while (obs_q.size() < base + exp_q.size() && g < 800) begin step(); g++; end
        repeat (5) step();
        chk({tag, "_count"}, 32'(obs_q.size() - base), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && base + i < obs_q.size(); i++)
            chk({tag, "_feature"}, 32'(obs_q[base + i]), 32'(exp_q[i]));
    endtask

    task automatic do_result(input int target, input logic [7:0] val);
        int g;
        g = 0;
        while (cyc < target && g < 1000) begin step(); g++; end
        mac_done = 1'b1; mac_out = val;
        step();
        mac_done = 1'b0; mac_out = 8'd0;
        chk("result_valid", 32'(r_valid), 32'd1);
        chk("result_data", 32'(r_data), 32'(val));
        step();
        chk("result_released", 32'(r_valid), 32'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_s_ready"}, 32'(s_ready), 32'd1);
        chk({tag, "_mac_start"}, 32'(mac_start), 32'd0);
        chk({tag, "_mac_data"}, 32'(mac_data), 32'd0);
        chk({tag, "_mac_index"}, 32'(mac_index), 32'd0);
        chk({tag, "_r_valid"}, 32'(r_valid), 32'd0);
        chk({tag, "_r_data"}, 32'(r_data), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_err_len"}, 32'(err_len), 32'd0);
        chk({tag, "_err_timeout"}, 32'(err_timeout), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: observed=still running expected=finished");
        $fatal(1);
    end

    initial begin
        int base, base_b, e_last, el0, to0, rv0, acc;
        logic ok;
        rst = 1'b1; s_valid = 1'b0; s_data = 8'd0; s_last = 1'b0;
        mac_done = 1'b0; mac_out = 8'd0; r_ready = 1'b1;
        repeat (3) step();
        chk_reset_outputs("reset");
        rst = 1'b0;
        step();

        // mac_done while idle must not produce a result.
        mac_done = 1'b1; mac_out = 8'h33;
        step();
        mac_done = 1'b0;
        step();
        chk("stray_done_rvalid", 32'(r_valid), 32'd0);
        chk("stray_done_busy", 32'(busy), 32'd0);

        // Nominal frame 0x00..0x87 with result 0x5A.
        build_frame(FC, FC - 1, 1'b1);
        model_frame();
        base = obs_q.size(); el0 = n_err_len; rv0 = n_rvalid;
        send_range(0, FC, 1 << 30);
        check_frame("nominal", base);
        chk("first_latency", 32'(start_q[base] - first_acc_cyc), 32'd2);
        chk("sustained_rate", 32'(start_q[base + FC - 1] - start_q[base]), 32'(FC - 1));
        chk("nominal_err_len", 32'(n_err_len - el0), 32'(exp_err));
        do_result(start_q[start_q.size() - 1] + 136, 8'h5A);
        chk("nominal_rvalid_cycles", 32'(n_rvalid - rv0), 32'd1);
        chk("nominal_busy_end", 32'(busy), 32'd0);

        // Full frame without mac_done; FIFO fills while stalled; watchdog fires.
        build_frame(FC, FC - 1, 1'b0);
        model_frame();
        base = obs_q.size();
        send_range(0, FC, 1 << 30);
        check_frame("stall_a", base);
        e_last = start_q[start_q.size() - 1];
        to0 = n_to; rv0 = n_rvalid;
        build_frame(FC, FC - 1, 1'b0);
        base_b = obs_q.size();
        acc = 0;
        for (int k = 0; k < 20; k++) begin
            s_valid = 1'b1; s_data = tx_q[acc][7:0]; s_last = tx_q[acc][8];
            ok = s_ready;
            step();
            if (ok) acc++;
        end
        s_valid = 1'b0;
        chk("stall_accepts", 32'(acc), 32'd16);
        chk("stall_s_ready", 32'(s_ready), 32'd0);
        begin
            int g;
            g = 0;
            while (n_to == to0 && g < 400) begin step(); g++; end
        end
        chk("timeout_pulses", 32'(n_to - to0), 32'd1);
        chk("timeout_cycle", 32'(to_cyc - e_last), 32'd255);
        chk("timeout_busy", 32'(to_busy), 32'd0);
        chk("timeout_no_result", 32'(n_rvalid - rv0), 32'd0);
        send_range(16, FC, 1 << 30);
        model_frame();
        check_frame("stall_b", base_b);
        do_result(start_q[start_q.size() - 1] + 20, 8'($urandom_range(0, 255)));

        // Short frame: terminator on byte index 10.
        build_frame(11, 10, 1'b0);
        model_frame();
        base = obs_q.size(); el0 = n_err_len;
        send_range(0, 11, 1 << 30);
        check_frame("short", base);
        chk("short_err_len", 32'(n_err_len - el0), 32'(exp_err));
        chk("short_err_idx", 32'(err_len_idx), 32'd9);
        chk("short_err_nostart", 32'(err_len_with_start), 32'd0);
        chk("short_busy", 32'(busy), 32'd0);
        build_frame(FC, FC - 1, 1'b0);
        model_frame();
        base = obs_q.size();
        send_range(0, FC, 1 << 30);
        check_frame("after_short", base);
        do_result(start_q[start_q.size() - 1] + 30, 8'($urandom_range(0, 255)));

        // Long frame: 140 bytes, tail drained.
        build_frame(140, 139, 1'b0);
        model_frame();
        base = obs_q.size(); el0 = n_err_len;
        send_range(0, 140, 1 << 30);
        check_frame("long", base);
        chk("long_err_len", 32'(n_err_len - el0), 32'(exp_err));
        chk("long_err_idx", 32'(err_len_idx), 32'd135);
        chk("long_err_with_start", 32'(err_len_with_start), 32'd1);
        do_result(start_q[start_q.size() - 1] + 20, 8'($urandom_range(0, 255)));

        // Reset mid-frame with bytes buffered.
        build_frame(FC, FC - 1, 1'b0);
        model_frame();
        base = obs_q.size();
        send_range(0, FC, 1 << 30);
        check_frame("pre_reset", base);
        e_last = start_q[start_q.size() - 1];
        build_frame(FC, FC - 1, 1'b0);
        base_b = obs_q.size();
        send_range(0, 10, 1 << 30);
        do_result(e_last + 40, 8'($urandom_range(0, 255)));
        send_range(10, FC, base_b + 71);
        chk("reset_point_feature", 32'(obs_q[base_b + 70]), 32'({8'd70, tx_q[70][7:0]}));
        rst = 1'b1;
        #1;
        chk_reset_outputs("midreset");
        step();
        step();
        rst = 1'b0;
        step();
        chk("post_reset_mac_start", 32'(mac_start), 32'd0);
        chk("post_reset_busy", 32'(busy), 32'd0);
        build_frame(FC, FC - 1, 1'b0);
        model_frame();
        base = obs_q.size();
        send_range(0, FC, 1 << 30);
        check_frame("post_reset", base);
        do_result(start_q[start_q.size() - 1] + 50, 8'($urandom_range(0, 255)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
